fc8_vga_frame_capture: RTL

- Passive monitor on the VGA output of the fc8 graphics block (hsync, vsync, 3-3-2 RGB), sampled at the pixel-clock strobe.
- Recovers the pixel raster, measures line and frame timing, and computes a CRC-16 over each frame's active pixels.
- Latches one pixel at a programmable probe coordinate.
- Purpose: a self-checking graphics bench and a frame-signature check on hardware, with no waveform viewer required.

---
 rtl/fc8_vga_frame_capture_if.sv | 18 +
 rtl/fc8_vga_frame_capture.sv | 134 +++++++++++++
 2 files changed

// File: rtl/fc8_vga_frame_capture_if.sv
// fc8_vga_frame_capture_if
//   VGA output bus of the fc8 graphics block as seen by a passive monitor.
//   pix_ce              : one-master_clk pulse per pixel
//   vga_hsync/vga_vsync : raw sync lines (polarity set by the monitor)
//   vga_r/vga_g/vga_b   : 3-3-2 RGB
//   master : the graphics source (or a bench driving it)
//   slave  : the capture block
interface fc8_vga_frame_capture_if;
  logic       pix_ce;
  logic       vga_hsync;
  logic       vga_vsync;
  logic [2:0] vga_r;
  logic [2:0] vga_g;
  logic [1:0] vga_b;

  modport master (output pix_ce, vga_hsync, vga_vsync, vga_r, vga_g, vga_b);
  modport slave  (input  pix_ce, vga_hsync, vga_vsync, vga_r, vga_g, vga_b);
endinterface

// File: rtl/fc8_vga_frame_capture.sv
// fc8_vga_frame_capture
//   Passive VGA monitor: rebuilds the raster from hsync/vsync, measures line
//   and frame periods, CRC-16-CCITT (0x1021, init 0xFFFF) over each frame's
//   active pixels, and latches one pixel at a programmable probe coordinate.
// Ports
//   master_clk, master_rst_n : clock, async active-low reset
//   vga                      : VGA bus (slave modport), sampled on pix_ce
//   probe_x, probe_y         : active-area coordinate of the probe pixel
//   frame_done               : one-cycle pulse when frame results publish
//   frame_count              : completed frames (wraps)
//   frame_crc, frame_px_count: CRC / active pixel count of last frame
//   lines_per_frame          : vertical period of last frame, in lines
//   pix_per_line             : horizontal period of last line, in pix_ce ticks
//   probe_pixel, probe_valid : captured probe pixel, captured-at-least-once
//   locked                   : a vsync edge has been seen since reset
module fc8_vga_frame_capture #(
  parameter int H_START         = 85,
  parameter int V_START         = 22,
  parameter int H_ACTIVE        = 256,
  parameter int V_ACTIVE        = 240,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic                    master_clk,
  input  logic                    master_rst_n,
  fc8_vga_frame_capture_if.slave  vga,
  input  logic [8:0]              probe_x,
  input  logic [8:0]              probe_y,
  output logic                    frame_done,
  output logic [15:0]             frame_count,
  output logic [15:0]             frame_crc,
  output logic [16:0]             frame_px_count,
  output logic [9:0]              lines_per_frame,
  output logic [9:0]              pix_per_line,
  output logic [7:0]              probe_pixel,
  output logic                    probe_valid,
  output logic                    locked
);

  localparam logic       SYNC_POL = (SYNC_ACTIVE_LOW != 0);
  localparam logic [10:0] H_LO    = 11'(H_START);
  localparam logic [10:0] H_HI    = 11'(H_START + H_ACTIVE);
  localparam logic [10:0] V_LO    = 11'(V_START);
  localparam logic [10:0] V_HI    = 11'(V_START + V_ACTIVE);
  localparam logic [9:0]  CNT_MAX = 10'h3FF;

  // Byte-at-a-time CRC-16-CCITT step, MSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++)
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  logic [9:0]  hcnt, vcnt, hcnt_nxt, vcnt_nxt, x, y;
  logic [15:0] crc_acc;
  logic [16:0] px_acc;
  logic        hs_prev, vs_prev;
  logic        hs, vs, hs_edge, vs_edge, active, probe_hit;
  logic [7:0]  pix;

  // hs/vs are 1 when the sync is asserted, whatever the line polarity.
  assign hs  = vga.vga_hsync ^ SYNC_POL;
  assign vs  = vga.vga_vsync ^ SYNC_POL;
  assign pix = {vga.vga_r, vga.vga_g, vga.vga_b};

  // Raster position for the current sample, after this sample's counter
  // update, so the sync-edge sample itself sits at column/row 0.
  always_comb begin
    hs_edge  = hs & ~hs_prev;
    vs_edge  = vs & ~vs_prev;
    hcnt_nxt = hs_edge ? 10'd0 : (hcnt == CNT_MAX) ? hcnt : hcnt + 10'd1;
    vcnt_nxt = vs_edge ? 10'd0 :
               (hs_edge && vcnt != CNT_MAX) ? vcnt + 10'd1 : vcnt;
    active   = ({1'b0, hcnt_nxt} >= H_LO) && ({1'b0, hcnt_nxt} < H_HI) &&
               ({1'b0, vcnt_nxt} >= V_LO) && ({1'b0, vcnt_nxt} < V_HI);
    x        = hcnt_nxt - H_LO[9:0];
    y        = vcnt_nxt - V_LO[9:0];
    // x/y stay below H_ACTIVE/V_ACTIVE inside the window, so an
    // out-of-range probe simply never hits.
    probe_hit = active && (x == {1'b0, probe_x}) && (y == {1'b0, probe_y});
  end

  always_ff @(posedge master_clk or negedge master_rst_n) begin
    if (!master_rst_n) begin
      hcnt            <= '0;
      vcnt            <= '0;
      crc_acc         <= 16'hFFFF;
      px_acc          <= '0;
      hs_prev         <= 1'b0;
      vs_prev         <= 1'b0;
      frame_done      <= 1'b0;
      frame_count     <= '0;
      frame_crc       <= '0;
      frame_px_count  <= '0;
      lines_per_frame <= '0;
      pix_per_line    <= '0;
      probe_pixel     <= '0;
      probe_valid     <= 1'b0;
      locked          <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (vga.pix_ce) begin
        hs_prev <= hs;
        vs_prev <= vs;
        hcnt    <= hcnt_nxt;
        vcnt    <= vcnt_nxt;
        if (hs_edge) pix_per_line <= hcnt + 10'd1;
        if (vs_edge) begin
          // The first edge after reset only establishes frame alignment.
          if (locked) begin
            frame_crc       <= crc_acc;
            frame_px_count  <= px_acc;
            lines_per_frame <= vcnt + 10'd1;
            frame_count     <= frame_count + 16'd1;
            frame_done      <= 1'b1;
          end
          locked  <= 1'b1;
          // The edge sample opens the new frame, never closes the old one.
          crc_acc <= active ? crc_step(16'hFFFF, pix) : 16'hFFFF;
          px_acc  <= active ? 17'd1 : 17'd0;
        end else if (active) begin
          crc_acc <= crc_step(crc_acc, pix);
          px_acc  <= px_acc + 17'd1;
        end
        if (probe_hit) begin
          probe_pixel <= pix;
          probe_valid <= 1'b1;
        end
      end
    end
  end

endmodule
